// File: rtl/demux_pkg.sv
// Shared definitions for the demux_dist distributor: default data width,
// channel count and the channel-selection mode encoding.
package demux_pkg;

    localparam int unsigned WIDTH_DEF = 4;
    localparam int unsigned NUM_CHAN  = 4;

    typedef enum logic {
        MODE_SEL = 1'b0,
        MODE_RR  = 1'b1
    } mode_e;

endpackage : demux_pkg

// File: rtl/demux_chan.sv
// One distributor channel: data register plus valid flag.
// A load and an ack on the same edge resolve in favour of the load.
module demux_chan #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             ack,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] data,
    output logic             vld
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
            vld  <= 1'b0;
        end else if (load) begin
            data <= din;
            vld  <= 1'b1;
        end else if (ack) begin
            vld  <= 1'b0;
        end
    end

endmodule : demux_chan

// File: rtl/demux_dist.sv
// Four-channel data distributor: routes din to a channel chosen by sel or by a
// round-robin pointer, tracks per-channel valid flags and a sticky overflow.
module demux_dist
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_n,
    input  logic             mode,
    input  logic [1:0]       sel,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic [3:0]       ack,
    output logic [WIDTH-1:0] z0,
    output logic [WIDTH-1:0] z1,
    output logic [WIDTH-1:0] z2,
    output logic [WIDTH-1:0] z3,
    output logic [3:0]       vld,
    output logic [1:0]       ptr,
    output logic             ovf
);

    logic                accepted;
    logic                rr_mode;
    logic [1:0]          target;
    logic [NUM_CHAN-1:0] load_vec;
    logic [NUM_CHAN-1:0] ack_vec;
    logic [NUM_CHAN-1:0] vld_int;
    logic [WIDTH-1:0]    data [NUM_CHAN];

    always_comb begin
        accepted = load & ~en_n;
        rr_mode  = (mode_e'(mode) == MODE_RR);
        target   = rr_mode ? ptr : sel;
        ack_vec  = en_n ? '0 : ack;
        load_vec = '0;
        for (int unsigned i = 0; i < NUM_CHAN; i++) begin
            if (accepted && (target == 2'(i))) begin
                load_vec[i] = 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_CHAN; g++) begin : g_chan
        demux_chan #(.WIDTH(WIDTH)) u_chan (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load_vec[g]),
            .ack   (ack_vec[g]),
            .din   (din),
            .data  (data[g]),
            .vld   (vld_int[g])
        );
    end

    // Overflow is judged on the pre-edge flag; a same-edge ack frees the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            ovf <= 1'b0;
        end else begin
            if (accepted && rr_mode) begin
                ptr <= ptr + 2'd1;
            end
            if (accepted && vld_int[target] && !ack[target]) begin
                ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        z0  = en_n ? '0 : data[0];
        z1  = en_n ? '0 : data[1];
        z2  = en_n ? '0 : data[2];
        z3  = en_n ? '0 : data[3];
        vld = en_n ? '0 : vld_int;
    end

endmodule : demux_dist

// File: doc/demux_dist.md
DEMUX_DIST -- requirements
Module: demux_dist

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit width of data input and of each channel output.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en_n  input  1  active-low enable; 0 = operate, 1 = outputs blanked, loads/acks ignored.
REQ-005 SHALL have port mode  input  1  0 = channel from sel, 1 = round-robin channel from internal pointer.
REQ-006 SHALL have port sel  input  2  target channel in mode 0 (00→ch0, 01→ch1, 10→ch2, 11→ch3).
REQ-007 SHALL have port load  input  1  strobe; din is written to the target channel this cycle.
REQ-008 SHALL have port din  input  WIDTH  data to distribute.
REQ-009 SHALL have port ack  input  4  per-channel consume strobe; ack[i] clears vld[i].
REQ-010 SHALL have ports z0, z1, z2, z3  output  WIDTH each  channel data registers.
REQ-011 SHALL have port vld  output  4  per-channel data-valid flags.
REQ-012 SHALL have port ptr  output  2  current round-robin pointer.
REQ-013 SHALL have port ovf  output  1  sticky overflow flag.

Function
REQ-014 SHALL define "accepted load" as load=1 and en_n=0 at a rising clk edge.
REQ-015 SHALL select target = sel when mode=0, target = ptr when mode=1.
REQ-016 SHALL, on an accepted load, write din into channel register[target] and set vld[target]=1; visible on outputs 1 cycle after the edge.
REQ-017 SHALL leave all non-target channel registers and flags unchanged on a load.
REQ-018 SHALL increment ptr modulo 4 (3→0 wrap) on each accepted load in mode=1; ptr SHALL hold in mode=0 and when no load is accepted.
REQ-019 SHALL, with en_n=0, clear vld[i] on the edge where ack[i]=1, independently for each i.
REQ-020 SHALL, on simultaneous accepted load and ack to the same channel, load the new data and keep vld=1 (load wins); ovf unaffected.
REQ-021 SHALL set ovf=1 when an accepted load targets a channel with vld=1 and ack=0 at that edge; data is still overwritten.
REQ-022 SHALL keep ovf=1 until reset; no other clearing path.
REQ-023 SHALL, while en_n=1, drive z0..z3 = 0 and vld = 0 combinationally, ignore load and ack, and hold all internal state (data, flags, ptr, ovf).
REQ-024 SHALL, when en_n returns to 0, present the held internal state with no cycle of latency.
REQ-025 SHALL drive ptr and ovf regardless of en_n.
REQ-026 SHALL ignore mode and sel changes on edges without an accepted load.

Reset
REQ-027 SHALL, on rst_n=0, asynchronously clear all channel registers to 0, vld to 0000, ptr to 00, ovf to 0.
REQ-028 SHALL discard any load or ack coinciding with reset; first accepted load after rst_n deasserts targets ch0 in mode=1.
REQ-029 SHALL apply reset mid-operation identically; no partially updated channel after release.

Structure
REQ-030 SHALL place WIDTH default, channel count (4) and mode encodings (MODE_SEL=0, MODE_RR=1) in shared package demux_pkg.
REQ-031 SHALL implement each channel (data register plus vld flag plus load/ack priority) as sub-module demux_chan, instantiated four times.
REQ-032 SHALL keep pointer, target decode, overflow and en_n output blanking in demux_dist top level.

Verification
REQ-033 SHALL cover: reset, en_n=0, mode=0, sel=10, din=1010, load 1 cycle -> next cycle z2=1010, vld=0100, others 0, ovf=0.
REQ-034 SHALL cover: mode=1, five loads din=1,2,3,4,5 -> ptr 0→1→2→3→0→1; z0=5, z1=2, z2=3, z3=4, vld=1111, ovf=1.
REQ-035 SHALL cover: ch1 valid, same edge load to ch1 (din=0111) with ack[1]=1 -> z1=0111, vld[1]=1, ovf=0.
REQ-036 SHALL cover: channels loaded, en_n=1 with load=1, ack=1111 -> z0..z3=0000, vld=0000; en_n=0 again -> original data and vld restored, ptr unchanged.
REQ-037 SHALL cover: rst_n asserted asynchronously mid-cycle after loads -> all outputs 0, ptr=00, ovf=0 immediately, without waiting for clk.
